timer_irq_controller: RTL

//  Interrupt scheduler for Timer0/1/2 flags. Arbitrates the pending TIFR&TIMSK sources by fixed ATMega32A priority.

---
 rtl/timer_irq_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/timer_irq_controller.sv
// ---------------------------------------------------------------------------
// timer_irq_controller
//
// Interrupt scheduler for the Timer0/1/2 flags of an ATMega32A-style core.
// The pending sources (TIFR & TIMSK) are arbitrated by fixed priority, with
// bit 7 highest and bit 0 lowest. The winner is presented to the CPU as a
// request plus its vector address, and a req/ack handshake follows. When the
// CPU acknowledges, a one-cycle one-hot flag_clear pulse tells the timer
// register blocks to clear the serviced TIFR bit. This is the hardware clear
// on vector entry.
//
// Optional feature macro: TIMER_IRQ_TIMEOUT_EN
//   defined   : a request left unacknowledged for ACK_TIMEOUT cycles is
//               abandoned. The flag stays set and is arbitrated again.
//   undefined : a request waits for ack or a withdraw condition indefinitely.
//
// Parameters
//   VECTOR_BASE  word address of the TIMER2_COMP vector (TIFR bit 7)
//   VECTOR_STEP  word distance between consecutive vectors
//   ACK_TIMEOUT  REQ cycles before the request is abandoned (timeout build only)
//
// Ports
//   sysClock    in   1   system clock, rising edge
//   rst_n       in   1   synchronous reset, active-low
//   TIFR_in     in   8   timer flags (OCF2,TOV2,ICF1,OCF1A,OCF1B,TOV1,OCF0,TOV0)
//   TIMSK_in    in   8   timer interrupt enables, same bit map
//   global_ie   in   1   SREG I bit
//   irq_ack     in   1   CPU accepts the current request (1-cycle pulse)
//   irq_req     out  1   interrupt request to the CPU
//   irq_vector  out  16  vector word address of the granted source
//   irq_index   out  3   TIFR bit number of the granted source
//   flag_clear  out  8   one-hot 1-cycle clear pulse for TIFR
//   busy        out  1   controller is not idle
// ---------------------------------------------------------------------------
module timer_irq_controller #(
    parameter logic [15:0] VECTOR_BASE = 16'h0008,
    parameter int          VECTOR_STEP = 2,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic        sysClock,
    input  logic        rst_n,
    input  logic [7:0]  TIFR_in,
    input  logic [7:0]  TIMSK_in,
    input  logic        global_ie,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    output logic [2:0]  irq_index,
    output logic [7:0]  flag_clear,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CLEAR = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req_nxt;
    logic [7:0]  clear_nxt;
    logic [2:0]  index_nxt;
    logic [15:0] vector_nxt;

    logic [7:0]  pending;
    logic [2:0]  winner;
    logic [15:0] winner_vector;
    logic        withdraw;
    logic        timeout_hit;

    assign pending = TIFR_in & TIMSK_in;

    // Fixed-priority encoder. Later loop iterations override earlier ones,
    // so the highest set bit wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                winner = 3'(i);
            end
        end
    end

    // Vectors are ordered from bit 7 (lowest address) down to bit 0.
    assign winner_vector = VECTOR_BASE + 16'(VECTOR_STEP * (7 - int'(winner)));

    // A granted request is withdrawn when the source is no longer both
    // flagged and enabled, or when interrupts are globally disabled.
    assign withdraw = !global_ie || !TIFR_in[irq_index] || !TIMSK_in[irq_index];

`ifdef TIMER_IRQ_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // The wait counter is zero outside REQ, so it is already clear on REQ
    // entry. It reads k in the (k+1)-th REQ cycle. The request is therefore
    // abandoned after exactly ACK_TIMEOUT cycles.
    always_ff @(posedge sysClock) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state != REQ) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (wait_cnt == 8'(ACK_TIMEOUT - 1));
`else
    // Without the timeout feature, ACK_TIMEOUT has no effect.
    localparam int unused_ack_timeout = ACK_TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear during the cycle that the next state
    // occupies. For example, the flag_clear pulse is visible exactly while
    // the controller is in CLEAR.
    always_comb begin
        state_nxt  = state;
        req_nxt    = 1'b0;
        clear_nxt  = 8'h00;
        index_nxt  = irq_index;
        vector_nxt = irq_vector;
        case (state)
            IDLE: begin
                if (global_ie && (|pending)) begin
                    state_nxt  = REQ;
                    req_nxt    = 1'b1;
                    index_nxt  = winner;
                    vector_nxt = winner_vector;
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous withdraw or
                // timeout. The granted source is never preempted here.
                if (irq_ack) begin
                    state_nxt = CLEAR;
                    clear_nxt = 8'h01 << irq_index;
                end else if (withdraw || timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    req_nxt = 1'b1;
                end
            end
            CLEAR: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sysClock) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_vector <= 16'h0000;
            irq_index  <= 3'd0;
            flag_clear <= 8'h00;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            irq_req    <= req_nxt;
            irq_vector <= vector_nxt;
            irq_index  <= index_nxt;
            flag_clear <= clear_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule
